hilo_muldiv_ctrl: RTL and testbench

//  Execute-stage sequencer for the shared multiply/divide resource and the HI/LO register pair.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 25 ++
 rtl/hilo_muldiv_ctrl_div_iter.sv | 47 ++++
 rtl/hilo_muldiv_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Optional build macro HILO_DIV0_FAST_EN is consumed by hilo_muldiv_ctrl.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // Replicated across the full HI/LO width at reset
    localparam logic HILO_RESET_VAL = 1'b0;

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Unsigned restoring divider on magnitudes, one quotient bit per step.
// Build option: none (HILO_DIV0_FAST_EN handled by the parent).
module hilo_muldiv_ctrl_div_iter
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] quotReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   trial;

    // Dividend bits shift out of quotReg's top while quotient bits shift in
    assign remShift = {remReg, quotReg[WIDTH-1]};
    assign trial    = remShift - {1'b0, divisorReg};

    always_ff @(posedge clk) begin
        if (reset) begin
            quotReg    <= '0;
            remReg     <= '0;
            divisorReg <= '0;
        end else if (start) begin
            quotReg    <= dividend;
            remReg     <= '0;
            divisorReg <= divisor;
        end else if (step) begin
            quotReg <= {quotReg[WIDTH-2:0], ~trial[WIDTH]};
            remReg  <= trial[WIDTH] ? remShift[WIDTH-1:0]
                                    : trial[WIDTH-1:0];
        end
    end

    assign quot = quotReg;
    assign rem  = remReg;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage sequencer for the shared mul/div unit and the HI/LO pair.
// Define HILO_DIV0_FAST_EN to finish divide-by-zero one cycle after acceptance.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  md_op_t           req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);

    md_state_t state;
    md_state_t stateNext;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic [WIDTH-1:0] hiNext;
    logic [WIDTH-1:0] loNext;
    logic             doneNext;
    logic             accept;
    logic             mulLoad;
    logic             divStart;
    logic             divStep;

    logic             mulSigned;
    logic [2*WIDTH-1:0] mulA;
    logic [2*WIDTH-1:0] mulB;
    logic [2*WIDTH-1:0] mulProd;
    logic [2*WIDTH-1:0] mulPipe [MUL_LAT];

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic             sgnQ;
    logic             sgnR;
    logic             divZero;
    logic [WIDTH-1:0] divA;
    logic [WIDTH-1:0] quotMag;
    logic [WIDTH-1:0] remMag;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;

    assign busy   = (state != ST_IDLE);
    assign stall  = busy & (req_valid | hilo_rd);
    assign accept = (state == ST_IDLE) & req_valid & ~flush
                  & (req_op != MD_NONE);

    // Extending to 2W makes one 2W multiply serve both signednesses
    assign mulSigned = (req_op == MD_MULT);
    assign mulA = {{WIDTH{mulSigned & req_a[WIDTH-1]}}, req_a};
    assign mulB = {{WIDTH{mulSigned & req_b[WIDTH-1]}}, req_b};
    assign mulProd = mulA * mulB;

    always_ff @(posedge clk) begin
        if (mulLoad) begin
            mulPipe[0] <= mulProd;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            mulPipe[i] <= mulPipe[i-1];
        end
    end

    assign aNeg = (req_op == MD_DIV) & req_a[WIDTH-1];
    assign bNeg = (req_op == MD_DIV) & req_b[WIDTH-1];
    assign absA = aNeg ? -req_a : req_a;
    assign absB = bNeg ? -req_b : req_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sgnQ    <= 1'b0;
            sgnR    <= 1'b0;
            divZero <= 1'b0;
            divA    <= '0;
        end else if (divStart) begin
            sgnQ    <= aNeg ^ bNeg;
            sgnR    <= aNeg;
            divZero <= (req_b == '0);
            divA    <= req_a;
        end
    end

    hilo_muldiv_ctrl_div_iter #(
        .WIDTH(WIDTH)
    ) divIter (
        .clk     (clk),
        .reset   (reset),
        .start   (divStart),
        .step    (divStep),
        .dividend(absA),
        .divisor (absB),
        .quot    (quotMag),
        .rem     (remMag)
    );

    // Remainder follows the dividend sign; x/0 yields all-ones, rem=x
    assign fixLo = divZero ? '1   : (sgnQ ? -quotMag : quotMag);
    assign fixHi = divZero ? divA : (sgnR ? -remMag : remMag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= {WIDTH{HILO_RESET_VAL}};
            lo    <= {WIDTH{HILO_RESET_VAL}};
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            hi    <= hiNext;
            lo    <= loNext;
            done  <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        hiNext    = hi;
        loNext    = lo;
        doneNext  = 1'b0;
        mulLoad   = 1'b0;
        divStart  = 1'b0;
        divStep   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op)
                        MD_MTHI: hiNext = req_a;
                        MD_MTLO: loNext = req_a;
                        MD_MULT, MD_MULTU: begin
                            mulLoad   = 1'b1;
                            stateNext = ST_MUL;
                            cntNext   = MUL_CNT;
                        end
                        MD_DIV, MD_DIVU: begin
                            divStart  = 1'b1;
                            stateNext = ST_DIV;
                            cntNext   = DIV_CNT;
`ifdef HILO_DIV0_FAST_EN
                            if (req_b == '0) begin
                                stateNext = ST_FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    stateNext = ST_IDLE;
                end else if (cnt == '0) begin
                    {hiNext, loNext} = mulPipe[MUL_LAT-1];
                    doneNext  = 1'b1;
                    stateNext = ST_IDLE;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    stateNext = ST_IDLE;
                end else begin
                    divStep = 1'b1;
                    if (cnt == '0) begin
                        stateNext = ST_FIX;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
            end
            ST_FIX: begin
                stateNext = ST_IDLE;
                if (!flush) begin
                    hiNext   = fixHi;
                    loNext   = fixLo;
                    doneNext = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed table-driven bench for hilo_muldiv_ctrl.
// Honours HILO_DIV0_FAST_EN for divide-by-zero latency.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;
`ifdef HILO_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    logic             clk;
    logic             reset;
    logic             req_valid;
    md_op_t           req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             hilo_rd;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int tests;
    int errors;

    hilo_muldiv_ctrl #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .hilo_rd  (hilo_rd),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runOp(input md_op_t op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output int busyCnt);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        lat       = -1;
        busyCnt   = 0;
        if (busy) busyCnt++;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (busy) busyCnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulseOp(input md_op_t op, input logic [31:0] a,
                           input logic fl);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        flush     = fl;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        flush     = 1'b0;
    endtask

    task automatic noDoneFor(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        int bc;
        tests     = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        req_a     = '0;
        req_b     = '0;
        hilo_rd   = 1'b0;
        flush     = 1'b0;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,
                    32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,
                    32'h00000001, 32'hFFFFFFFE, MUL_LAT};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{MD_DIVU,  32'd100, 32'd7,
                    32'd2, 32'd14, 33};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000, 33};
        vecs[5] = '{MD_DIVU,  32'd5, 32'd0,
                    32'd5, 32'hFFFFFFFF, DIV0_LAT};
        vecs[6] = '{MD_DIV,   32'hFFFFFFEC, 32'd0,
                    32'hFFFFFFEC, 32'hFFFFFFFF, DIV0_LAT};
        vecs[7] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,
                    32'h3FFFFFFF, 32'h00000001, MUL_LAT};
        vecs[8] = '{MD_DIV,   32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD, 33};
        vecs[9] = '{MD_MULTU, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h0, MUL_LAT};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].expHi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].expLo));
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].expLat));
            check($sformatf("v%0d_busy", i), 64'(bc), 64'(vecs[i].expLat));
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // MD_NONE is a no-op
        pulseOp(MD_NONE, 32'hDEAD, 1'b0);
        check("none_busy", 64'(busy), 64'd0);
        check("none_lo", 64'(lo), 64'h0);

        // Reset in the middle of a divide
        pulseOp(MD_DIVU, 32'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstmid_hi", 64'(hi), 64'd0);
        check("rstmid_lo", 64'(lo), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        noDoneFor("rstmid_nodone", 40);

        // Flush at cycle 10 of a divide
        pulseOp(MD_MTHI, 32'h11, 1'b0);
        check("mthi", 64'(hi), 64'h11);
        check("mthi_busy", 64'(busy), 64'd0);
        pulseOp(MD_MTLO, 32'h22, 1'b0);
        check("mtlo", 64'(lo), 64'h22);
        req_b = 32'd7;
        pulseOp(MD_DIVU, 32'd100, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h11);
        check("flush_lo", 64'(lo), 64'h22);
        noDoneFor("flush_nodone", 40);
        check("flush_hi_late", 64'(hi), 64'h11);
        pulseOp(MD_MTLO, 32'h33, 1'b0);
        check("mtlo_after_flush", 64'(lo), 64'h33);

        // Flush in IDLE drops even MTHI
        pulseOp(MD_MTHI, 32'h99, 1'b1);
        check("flush_idle_hi", 64'(hi), 64'h11);

        // hilo_rd during MUL stalls each busy cycle
        hilo_rd = 1'b1;
        runOp(MD_MULTU, 32'd3, 32'd4, lat, bc);
        check("rd_done_stall", 64'(stall), 64'd0);
        check("rd_lo", 64'(lo), 64'd12);
        hilo_rd = 1'b0;

        // MTHI held under stall lands after the mult result
        begin
            int stallCnt;
            int doneAt;
            stallCnt  = 0;
            doneAt    = -1;
            req_valid = 1'b1;
            req_op    = MD_MULT;
            req_a     = 32'd6;
            req_b     = 32'd7;
            @(posedge clk);
            #1;
            req_op = MD_MTHI;
            req_a  = 32'h55;
            if (stall) stallCnt++;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    doneAt = i;
                    break;
                end
                if (stall) stallCnt++;
            end
            check("mthi_mul_stalls", 64'(stallCnt), 64'(MUL_LAT));
            check("mthi_mul_lat", 64'(doneAt), 64'(MUL_LAT));
            check("mthi_mul_stall0", 64'(stall), 64'd0);
            check("mthi_mul_hi", 64'(hi), 64'd0);
            check("mthi_mul_lo", 64'(lo), 64'd42);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_op    = MD_NONE;
            check("mthi_after_hi", 64'(hi), 64'h55);
            check("mthi_after_lo", 64'(lo), 64'd42);
            check("mthi_after_done", 64'(done), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
